ecc_apb_sequencer: RTL and testbench
====================================

Name: ecc_apb_sequencer

Overview:
- APB master that sequences the ECC_ENC_DEC core for one job at a time.
- Accepts a job (operation, data, codeword width, noise) on a valid/ready interface.
- Programs the core's four registers over APB, waits for operation_done, then returns data_out and num_of_errors on a valid/ready result interface.
- Sits between the system job source and the ECC_ENC_DEC APB slave.

Parameters:
- AMBA_WORD, 32, APB data width.
- AMBA_ADDR_WIDTH, 20, APB address width.
- DATA_WIDTH, 32, maximum codeword width / data bus width of the core.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- job_valid  in  1  job request.
- job_ready  out  1  sequencer can accept a job.
- job_op  in  2  CTRL value: 0 encode, 1 decode, 2 full channel; 3 reserved.
- job_data  in  DATA_WIDTH  word for the DATA_IN register.
- job_width  in  2  CODEWORD_WIDTH value: 0 = 8 bit, 1 = 16 bit, 2 = 32 bit.
- job_noise  in  DATA_WIDTH  word for the NOISE register.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PRDATA  in  AMBA_WORD  APB read data; unused, reserved.
- operation_done  in  1  core completion pulse.
- data_out  in  DATA_WIDTH  core result.
- num_of_errors  in  2  core error count.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_WIDTH  captured data_out.
- res_errors  out  2  captured num_of_errors.
- res_timeout  out  1  result produced by timeout (see Optional Feature).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs are 0 except job_ready = 1.
- Reset mid-transfer drops PSEL and PENABLE immediately and discards the job and any pending result.
- The ECC slave has no PREADY; every write takes exactly 2 cycles (SETUP, then ACCESS).
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE:
  - job_ready = 1.
  - On job_valid & job_ready, latch all job fields and set reg index = 0; next state SETUP.
  - job_op == 3 is rejected: job_ready stays 1, the job is dropped and the FSM stays in IDLE.
- Write order by reg index:
  - 0: DATA_IN, 0x04, PWDATA = job_data.
  - 1: CODEWORD_WIDTH, 0x08, PWDATA = zero-extended job_width.
  - 2: NOISE, 0x0C, PWDATA = job_noise.
  - 3: CTRL, 0x00, PWDATA = zero-extended job_op.
  - CTRL is always written last because writing CTRL starts the operation.
- PADDR carries the register offset zero-extended to AMBA_ADDR_WIDTH.
- SETUP: PSEL = 1, PENABLE = 0, PWRITE = 1, PADDR and PWDATA valid; next state ACCESS.
- ACCESS: PENABLE = 1, all other APB outputs held.
  - Index < 3: increment index; next state SETUP. PSEL stays 1 between writes; PENABLE returns to 0.
  - Index == 3: next state WAIT_DONE with PSEL = PENABLE = PWRITE = 0.
- Job acceptance to the end of the CTRL ACCESS cycle is 8 cycles.
- operation_done is ignored outside WAIT_DONE; stale pulses during programming are dropped.
- WAIT_DONE: on operation_done, capture data_out and num_of_errors; res_timeout = 0; next state RESP.
- RESP:
  - res_valid = 1 from the cycle after operation_done.
  - res_data, res_errors and res_timeout are stable while res_valid = 1.
  - On res_ready, drop res_valid; next state IDLE.
- job_ready is 1 only in IDLE; a new job is accepted no earlier than the cycle after the result handshake.
- A simultaneous operation_done and reset is won by reset.

Optional Feature:
- Macro: ECC_SEQ_TIMEOUT_EN.
- With the macro:
  - Parameter TIMEOUT_CYCLES, default 64.
  - A counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES-1 without operation_done, go to RESP with res_data = 0, res_errors = 2'b11, res_timeout = 1.
- Without the macro: WAIT_DONE waits indefinitely and res_timeout is tied to 0.

Decomposition:
- Package ecc_seq_pkg holds:
  - register offsets: CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C;
  - op enum: ENCODE = 0, DECODE = 1, FULL = 2;
  - width enum: W8, W16, W32;
  - FSM state enum.
- Sub-module apb_write_master: a 2-cycle write engine with a start/done handshake, instantiated once.

Test Plan:
- Encode job (op = 0, data = 0x0A, width = 0, noise = 0):
  - APB writes appear as 0x04/0x0A, 0x08/0x0, 0x0C/0x0, 0x00/0x0, each 2 cycles with PSEL continuous.
  - Driving operation_done 3 cycles later with data_out = 0x5A, errors = 0 gives res_valid one cycle later with res_data = 0x5A.
- Full-channel job (op = 2, noise = 0x20):
  - The last write is CTRL = 0x2.
  - errors = 1 returns res_errors = 1.
  - With res_ready held low for 5 cycles, the result stays stable and job_ready stays 0.
- An operation_done pulse during the NOISE write is ignored; only the post-CTRL pulse is captured.
- Reset asserted during the DATA_IN ACCESS cycle:
  - PSEL and PENABLE go to 0 immediately and job_ready = 1.
  - After release, a fresh job runs normally.
- job_op = 3 is not accepted: no APB activity and busy stays 0.
- With ECC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no operation_done gives res_valid with res_timeout = 1, res_errors = 3 and res_data = 0, 16 cycles after entering WAIT_DONE.

Source files
------------

// File: rtl/ecc_seq_pkg.sv
// ecc_seq_pkg: register map, job enums and FSM states
// shared by the ECC_ENC_DEC APB sequencer files.
package ecc_seq_pkg;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_DATA_IN  = 8'h04;
   localparam logic [7:0] REG_CW_WIDTH = 8'h08;
   localparam logic [7:0] REG_NOISE    = 8'h0C;

   typedef enum logic [1:0] {
      ENCODE = 2'd0,
      DECODE = 2'd1,
      FULL   = 2'd2
   } op_e;

   localparam logic [1:0] OP_RSVD = 2'd3;

   typedef enum logic [1:0] {
      W8  = 2'd0,
      W16 = 2'd1,
      W32 = 2'd2
   } width_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SETUP     = 3'd1,
      ST_ACCESS    = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } state_e;

   // Programming order: CTRL last, since writing it starts the core.
   function automatic logic [7:0] reg_offset(input logic [1:0] idx);
      logic [7:0] off;
      case (idx)
         2'd0:    off = REG_DATA_IN;
         2'd1:    off = REG_CW_WIDTH;
         2'd2:    off = REG_NOISE;
         default: off = REG_CTRL;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/apb_write_master.sv
// apb_write_master: 2-cycle APB write engine (SETUP, ACCESS).
// A start during ACCESS chains the next write with PSEL held high.
module apb_write_master #(
   parameter int AW = 20,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_psel,
   output logic          o_penable,
   output logic          o_pwrite,
   output logic [AW-1:0] o_paddr,
   output logic [DW-1:0] o_pwdata,
   output logic          o_done
);

   logic          r_psel;
   logic          r_penable;
   logic          r_pwrite;
   logic [AW-1:0] r_paddr;
   logic [DW-1:0] r_pwdata;

   // Load a transfer on start, then step SETUP -> ACCESS -> idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
      end else if (i_start) begin
         r_psel    <= 1'b1;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b1;
         r_paddr   <= i_addr;
         r_pwdata  <= i_wdata;
      end else if (r_psel && !r_penable) begin
         r_penable <= 1'b1;
      end else begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
      end
   end

   assign o_psel    = r_psel;
   assign o_penable = r_penable;
   assign o_pwrite  = r_pwrite;
   assign o_paddr   = r_paddr;
   assign o_pwdata  = r_pwdata;
   assign o_done    = r_psel & r_penable;

endmodule

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: programs ECC_ENC_DEC over APB per job.
// Optional WAIT_DONE timeout: define ECC_SEQ_TIMEOUT_EN.
module ecc_apb_sequencer
   import ecc_seq_pkg::*;
#(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int DATA_WIDTH      = 32
`ifdef ECC_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES  = 64
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [1:0]                 job_op,
   input  logic [DATA_WIDTH-1:0]      job_data,
   input  logic [1:0]                 job_width,
   input  logic [DATA_WIDTH-1:0]      job_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic [AMBA_WORD-1:0]       PRDATA,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [DATA_WIDTH-1:0]      res_data,
   output logic [1:0]                 res_errors,
   output logic                       res_timeout,
   output logic                       busy
);

   state_e                     r_state;
   state_e                     w_next;
   logic [1:0]                 r_idx;
   logic [1:0]                 r_op;
   logic [1:0]                 r_width;
   logic [DATA_WIDTH-1:0]      r_noise;
   logic [DATA_WIDTH-1:0]      r_res_data;
   logic [1:0]                 r_res_err;
   logic                       w_accept;
   logic                       w_last;
   logic                       w_start;
   logic                       w_timeout;
   logic                       w_done;
   logic [1:0]                 w_idx;
   logic [AMBA_ADDR_WIDTH-1:0] w_addr;
   logic [AMBA_WORD-1:0]       w_wdata;
   logic                       w_unused;

   assign w_unused = ^PRDATA;

   assign w_accept = (r_state == ST_IDLE) && job_valid
                     && (job_op != OP_RSVD);
   assign w_last   = (r_state == ST_ACCESS) && (r_idx == 2'd3);
   assign w_start  = w_accept
                     || ((r_state == ST_ACCESS) && (r_idx != 2'd3));
   assign w_idx    = (r_state == ST_IDLE) ? 2'd0 : r_idx + 2'd1;
   assign w_addr   = AMBA_ADDR_WIDTH'(reg_offset(w_idx));

   // Write data for the register about to be programmed.
   always_comb begin
      w_wdata = '0;
      case (w_idx)
         2'd0:    w_wdata = AMBA_WORD'(job_data);
         2'd1:    w_wdata = AMBA_WORD'(r_width);
         2'd2:    w_wdata = AMBA_WORD'(r_noise);
         default: w_wdata = AMBA_WORD'(r_op);
      endcase
   end

   apb_write_master #(
      .AW (AMBA_ADDR_WIDTH),
      .DW (AMBA_WORD)
   ) u_wr (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_addr    (w_addr),
      .i_wdata   (w_wdata),
      .o_psel    (PSEL),
      .o_penable (PENABLE),
      .o_pwrite  (PWRITE),
      .o_paddr   (PADDR),
      .o_pwdata  (PWDATA),
      .o_done    (w_done)
   );

`ifdef ECC_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] r_cnt;
   logic          r_res_to;

   // Cycles spent in WAIT_DONE; restarts for every job.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else if (w_last)
         r_cnt <= '0;
      else if (r_state == ST_WAIT_DONE)
         r_cnt <= r_cnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_WAIT_DONE)
                      && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign res_timeout = r_res_to;
`else
   assign w_timeout   = 1'b0;
   assign res_timeout = 1'b0;
`endif

   // Next-state selection for the job sequencing FSM.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (w_accept) w_next = ST_SETUP;
         ST_SETUP:     w_next = ST_ACCESS;
         ST_ACCESS:    w_next = w_last ? ST_WAIT_DONE : ST_SETUP;
         ST_WAIT_DONE: if (operation_done || w_timeout)
                          w_next = ST_RESP;
         ST_RESP:      if (res_ready) w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   // State register and register index of the current write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_idx   <= 2'd0;
      end else begin
         r_state <= w_next;
         if (w_accept)
            r_idx <= 2'd0;
         else if (w_done && (r_idx != 2'd3))
            r_idx <= r_idx + 2'd1;
      end
   end

   // Job fields still needed after the DATA_IN write is launched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op    <= 2'd0;
         r_width <= 2'd0;
         r_noise <= '0;
      end else if (w_accept) begin
         r_op    <= job_op;
         r_width <= job_width;
         r_noise <= job_noise;
      end
   end

   // Result capture; held stable until the consumer takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_res_data <= '0;
         r_res_err  <= 2'd0;
`ifdef ECC_SEQ_TIMEOUT_EN
         r_res_to   <= 1'b0;
`endif
      end else if (r_state == ST_WAIT_DONE) begin
         if (operation_done) begin
            r_res_data <= data_out;
            r_res_err  <= num_of_errors;
`ifdef ECC_SEQ_TIMEOUT_EN
            r_res_to   <= 1'b0;
`endif
         end else if (w_timeout) begin
            r_res_data <= '0;
            r_res_err  <= 2'b11;
`ifdef ECC_SEQ_TIMEOUT_EN
            r_res_to   <= 1'b1;
`endif
         end
      end
   end

   assign job_ready  = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign res_valid  = (r_state == ST_RESP);
   assign res_data   = r_res_data;
   assign res_errors = r_res_err;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: directed + randomized jobs against
// a register-write list model of the ECC APB sequencer.
module tb_ecc_apb_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [1:0]  job_op = '0;
   logic [31:0] job_data = '0;
   logic [1:0]  job_width = '0;
   logic [31:0] job_noise = '0;
   logic [19:0] PADDR;
   logic [31:0] PWDATA;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PRDATA = '0;
   logic        operation_done = 1'b0;
   logic [31:0] data_out = '0;
   logic [1:0]  num_of_errors = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic [1:0]  res_errors;
   logic        res_timeout;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ecc_apb_sequencer #(
      .AMBA_WORD       (32),
      .AMBA_ADDR_WIDTH (20),
      .DATA_WIDTH      (32)
`ifdef ECC_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES  (16)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_op         (job_op),
      .job_data       (job_data),
      .job_width      (job_width),
      .job_noise      (job_noise),
      .PADDR          (PADDR),
      .PWDATA         (PWDATA),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PRDATA         (PRDATA),
      .operation_done (operation_done),
      .data_out       (data_out),
      .num_of_errors  (num_of_errors),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .res_errors     (res_errors),
      .res_timeout    (res_timeout),
      .busy           (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Submit a job and check the 4 writes it must produce.
   task automatic program_job(input logic [1:0] op,
                              input logic [31:0] d,
                              input logic [1:0] w,
                              input logic [31:0] nz,
                              input bit stale);
      logic [19:0] ea [4];
      logic [31:0] ed [4];
      ea = '{20'h4, 20'h8, 20'hC, 20'h0};
      ed = '{d, {30'b0, w}, nz, {30'b0, op}};
      chk("idle_ready", job_ready, 1);
      chk("idle_busy", busy, 0);
      job_valid = 1'b1;
      job_op    = op;
      job_data  = d;
      job_width = w;
      job_noise = nz;
      step();
      job_valid = 1'b0;
      job_data  = $urandom;
      job_noise = $urandom;
      for (int c = 0; c < 8; c++) begin
         chk("psel", PSEL, 1);
         chk("penable", PENABLE, c % 2);
         chk("pwrite", PWRITE, 1);
         chk("paddr", PADDR, ea[c/2]);
         chk("pwdata", PWDATA, ed[c/2]);
         chk("prog_ready", job_ready, 0);
         chk("prog_busy", busy, 1);
         if (stale && (c == 4)) begin
            operation_done = 1'b1;
            data_out       = 32'hDEAD_BEEF;
            num_of_errors  = 2'b10;
         end else begin
            operation_done = 1'b0;
         end
         step();
      end
      operation_done = 1'b0;
   endtask

   task automatic run_job(input logic [1:0] op,
                          input logic [31:0] d,
                          input logic [1:0] w,
                          input logic [31:0] nz,
                          input int dly,
                          input logic [31:0] dout,
                          input logic [1:0] errs,
                          input int hold,
                          input bit stale);
      program_job(op, d, w, nz, stale);
      for (int c = 0; c < dly; c++) begin
         chk("wait_psel", PSEL, 0);
         chk("wait_pen", PENABLE, 0);
         chk("wait_pwrite", PWRITE, 0);
         chk("wait_valid", res_valid, 0);
         chk("wait_busy", busy, 1);
         step();
      end
      operation_done = 1'b1;
      data_out       = dout;
      num_of_errors  = errs;
      step();
      operation_done = 1'b0;
      for (int c = 0; c <= hold; c++) begin
         data_out      = $urandom;
         num_of_errors = 2'($urandom_range(0, 3));
         chk("res_valid", res_valid, 1);
         chk("res_data", res_data, dout);
         chk("res_errors", res_errors, errs);
         chk("res_timeout", res_timeout, 0);
         chk("resp_ready", job_ready, 0);
         res_ready = (c == hold);
         step();
      end
      res_ready = 1'b0;
      chk("post_valid", res_valid, 0);
      chk("post_ready", job_ready, 1);
      chk("post_busy", busy, 0);
   endtask

`ifdef ECC_SEQ_TIMEOUT_EN
   task automatic run_timeout();
      program_job(2'd0, $urandom, 2'd2, $urandom, 1'b0);
      for (int c = 0; c < 16; c++) begin
         chk("to_wait", res_valid, 0);
         step();
      end
      chk("to_valid", res_valid, 1);
      chk("to_flag", res_timeout, 1);
      chk("to_errors", res_errors, 3);
      chk("to_data", res_data, 0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("to_idle", job_ready, 1);
   endtask
`endif

   initial begin
      step();
      step();
      chk("rst_ready", job_ready, 1);
      chk("rst_psel", PSEL, 0);
      chk("rst_pen", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_err", res_errors, 0);
      chk("rst_to", res_timeout, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;
      step();

      run_job(2'd0, 32'h0A, 2'd0, 32'h0, 3, 32'h5A, 2'd0, 0, 1'b0);
      run_job(2'd2, $urandom, 2'd2, 32'h20, 1, $urandom, 2'd1, 5,
              1'b0);
      run_job(2'd1, $urandom, 2'd1, $urandom, 2, 32'h1234_5678,
              2'd2, 1, 1'b1);

      job_valid = 1'b1;
      job_op    = 2'd3;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("rsvd_psel", PSEL, 0);
         chk("rsvd_busy", busy, 0);
         chk("rsvd_ready", job_ready, 1);
      end
      job_valid = 1'b0;
      step();

      job_valid = 1'b1;
      job_op    = 2'd0;
      job_data  = 32'hCAFE;
      step();
      job_valid = 1'b0;
      step();
      chk("mid_pen", PENABLE, 1);
      rst = 1'b0;
      #1;
      chk("mid_psel", PSEL, 0);
      chk("mid_pen0", PENABLE, 0);
      chk("mid_ready", job_ready, 1);
      chk("mid_busy", busy, 0);
      step();
      rst = 1'b1;
      step();
      chk("rel_psel", PSEL, 0);
      run_job(2'd0, $urandom, 2'd0, $urandom, 0, $urandom, 2'd0, 0,
              1'b0);

      for (int j = 0; j < 6; j++) begin
         run_job(2'($urandom_range(0, 2)), $urandom,
                 2'($urandom_range(0, 2)), $urandom,
                 int'($urandom_range(0, 5)), $urandom,
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
      end

`ifdef ECC_SEQ_TIMEOUT_EN
      run_timeout();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
